// File: rtl/stack_ram_ctrl.sv
// Data-stack RAM sequencer: validates push/pop/peek/replace against the stack
// window, drives the external pointer register's function code, latches errors.
module stack_ram_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12,
  parameter int DEPTH  = 128,
  parameter int BASE   = 75,
  parameter int LVL_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Op_Valid,
  input  logic [1:0]        Op,
  input  logic [DATA_W-1:0] Data_In,
  input  logic [ADDR_W-1:0] S_Addr,
  input  logic              Clr_Err,
  output logic              Ready,
  output logic [1:0]        S_F_Out,
  output logic [DATA_W-1:0] Data_Out,
  output logic              Rd_Valid,
  output logic              Ovf,
  output logic              Unf,
  output logic [LVL_W-1:0]  Level
);
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PEEK = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  localparam logic [1:0] SF_HOLD = 2'b00;
  localparam logic [1:0] SF_INC  = 2'b01;
  localparam logic [1:0] SF_DEC  = 2'b10;

  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] ERR = 1'b1;

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] FULL_A = ADDR_W'(BASE + DEPTH);

  logic [0:0]        state;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              push_ok, rd_ok, rd_under, accept, wr_en;
  logic [IDX_W-1:0]  top_idx, below_idx, wr_idx;

  // Out-of-window pointers (foreign loads) fall through to the error paths.
  assign push_ok   = (S_Addr >= BASE_A) && (S_Addr < FULL_A);
  assign rd_ok     = (S_Addr > BASE_A) && (S_Addr <= FULL_A);
  assign rd_under  = (S_Addr <= BASE_A);
  assign top_idx   = IDX_W'(S_Addr - BASE_A);
  assign below_idx = top_idx - IDX_W'(1);

  assign Ready  = (state == RUN);
  assign Level  = LVL_W'(S_Addr - BASE_A);
  assign accept = rst_n && Ready && Op_Valid;

  assign wr_en  = accept && (((Op == OP_PUSH) && push_ok) || ((Op == OP_REPL) && rd_ok));
  assign wr_idx = (Op == OP_REPL) ? below_idx : top_idx;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= Data_In;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      S_F_Out  <= SF_HOLD;
      Data_Out <= '0;
      Rd_Valid <= 1'b0;
      Ovf      <= 1'b0;
      Unf      <= 1'b0;
    end else begin
      S_F_Out  <= SF_HOLD;
      Rd_Valid <= 1'b0;
      if (state == ERR) begin
        // Clearing consumes the cycle; a concurrent op is dropped.
        if (Clr_Err) begin
          state <= RUN;
          Ovf   <= 1'b0;
          Unf   <= 1'b0;
        end
      end else if (Op_Valid) begin
        case (Op)
          OP_PUSH: begin
            if (push_ok) S_F_Out <= SF_INC;
            else begin
              Ovf   <= 1'b1;
              state <= ERR;
            end
          end
          OP_POP, OP_PEEK: begin
            if (rd_ok) begin
              Data_Out <= mem[below_idx];
              Rd_Valid <= 1'b1;
              if (Op == OP_POP) S_F_Out <= SF_DEC;
            end else begin
              Unf   <= rd_under;
              Ovf   <= !rd_under;
              state <= ERR;
            end
          end
          default: begin
            if (!rd_ok) begin
              Unf   <= rd_under;
              Ovf   <= !rd_under;
              state <= ERR;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_stack_ram_ctrl.sv
// Scoreboard bench: a queue-based stack model predicts each cycle's outputs,
// a monitor compares them; the bench also plays the falling-edge pointer register.
module tb_stack_ram_ctrl;
  localparam int ADDR_W = 12, DATA_W = 12, DEPTH = 128, BASE = 75, LVL_W = 8;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              Op_Valid = 1'b0, Clr_Err = 1'b0;
  logic [1:0]        Op = 2'b00;
  logic [DATA_W-1:0] Data_In = '0;
  logic [ADDR_W-1:0] ptr;
  logic              Ready, Rd_Valid, Ovf, Unf;
  logic [1:0]        S_F_Out;
  logic [DATA_W-1:0] Data_Out;
  logic [LVL_W-1:0]  Level;

  stack_ram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE(BASE), .LVL_W(LVL_W)) dut (
    .clk(clk), .rst_n(rst_n), .Op_Valid(Op_Valid), .Op(Op), .Data_In(Data_In),
    .S_Addr(ptr), .Clr_Err(Clr_Err), .Ready(Ready), .S_F_Out(S_F_Out),
    .Data_Out(Data_Out), .Rd_Valid(Rd_Valid), .Ovf(Ovf), .Unf(Unf), .Level(Level));

  always #5 clk = ~clk;

  // External pointer register: samples S_F_Out on the falling edge.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= ADDR_W'(BASE);
    else if (S_F_Out == 2'b01) ptr <= ptr + 1'b1;
    else if (S_F_Out == 2'b10) ptr <= ptr - 1'b1;
  end

  typedef struct {
    logic [1:0]        sf;
    logic              rdy, ovf, unf, rdv;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] stk[$];
  bit                m_err, m_ovf, m_unf, mon_en;
  logic [DATA_W-1:0] m_data;
  int                n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bench cycle: drive inputs after the pointer update, predict the outcome.
  task automatic do_op(input bit v, input logic [1:0] op, input logic [DATA_W-1:0] din, input bit clr);
    exp_t e;
    @(negedge clk); #1;
    chk("s_addr", 32'(ptr), 32'(BASE + stk.size()));
    chk("level", 32'(Level), 32'(stk.size()));
    Op_Valid = v; Op = op; Data_In = din; Clr_Err = clr;
    e.sf = 2'b00; e.rdv = 1'b0;
    if (m_err) begin
      if (clr) begin m_err = 0; m_ovf = 0; m_unf = 0; end
    end else if (v) begin
      if (op == 2'b00) begin
        if (stk.size() < DEPTH) begin stk.push_back(din); e.sf = 2'b01; end
        else begin m_ovf = 1; m_err = 1; end
      end else if (stk.size() == 0) begin
        m_unf = 1; m_err = 1;
      end else if (op == 2'b01) begin
        m_data = stk.pop_back(); e.rdv = 1; e.sf = 2'b10;
      end else if (op == 2'b10) begin
        m_data = stk[$]; e.rdv = 1;
      end else begin
        stk[stk.size()-1] = din;
      end
    end
    e.rdy = !m_err; e.ovf = m_ovf; e.unf = m_unf; e.data = m_data;
    exp_q.push_back(e);
  endtask

  always begin
    @(posedge clk); #1;
    if (mon_en && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("s_f_out", 32'(S_F_Out), 32'(e.sf));
      chk("ready", 32'(Ready), 32'(e.rdy));
      chk("ovf", 32'(Ovf), 32'(e.ovf));
      chk("unf", 32'(Unf), 32'(e.unf));
      chk("rd_valid", 32'(Rd_Valid), 32'(e.rdv));
      chk("data_out", 32'(Data_Out), 32'(e.data));
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(Ready), 32'd1);
    chk({tag, "_sf"}, 32'(S_F_Out), 32'd0);
    chk({tag, "_data"}, 32'(Data_Out), 32'd0);
    chk({tag, "_rdv"}, 32'(Rd_Valid), 32'd0);
    chk({tag, "_ovf"}, 32'(Ovf), 32'd0);
    chk({tag, "_unf"}, 32'(Unf), 32'd0);
  endtask

  task automatic model_reset();
    stk.delete(); exp_q.delete();
    m_err = 0; m_ovf = 0; m_unf = 0; m_data = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    mon_en = 1'b0;
    #12;
    chk_reset_outputs("por");
    chk("por_ptr", 32'(ptr), 32'(BASE));
    @(negedge clk); rst_n = 1'b1;
    mon_en = 1'b1;

    do_op(1, 2'b00, 12'h0A5, 0);                 // single push
    do_op(1, 2'b00, 12'h111, 0);
    do_op(1, 2'b00, 12'h222, 0);
    do_op(1, 2'b01, '0, 0);
    do_op(1, 2'b01, '0, 0);
    do_op(1, 2'b01, '0, 0);                      // pops the 0A5
    do_op(1, 2'b01, '0, 0);                      // underflow on empty
    do_op(1, 2'b00, 12'h777, 0);                 // ignored in ERR
    do_op(0, 2'b00, '0, 1);                      // clear
    for (int i = 0; i < DEPTH; i++) do_op(1, 2'b00, DATA_W'(i * 37 + 5), 0);
    do_op(1, 2'b00, 12'hFFF, 0);                 // overflow at full
    do_op(1, 2'b01, '0, 1);                      // clear wins, pop dropped
    do_op(1, 2'b10, '0, 0);                      // peek sees 128th value
    do_op(1, 2'b11, 12'hABC, 0);
    do_op(1, 2'b10, '0, 0);
    do_op(1, 2'b01, '0, 0);                      // pop accepted, then reset below
    do_op(0, 2'b00, '0, 0);

    // Reset asserted in the cycle after a pop is accepted.
    @(negedge clk); #1;
    Op_Valid = 1'b1; Op = 2'b01; Clr_Err = 1'b0;
    @(posedge clk); #3;
    mon_en = 1'b0;
    rst_n = 1'b0; #1;
    chk_reset_outputs("mid");
    chk("mid_ptr", 32'(ptr), 32'(BASE));
    Op_Valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rdv", 32'(Rd_Valid), 32'd0);
    chk("post_rst_sf", 32'(S_F_Out), 32'd0);
    model_reset();
    mon_en = 1'b1;

    do_op(1, 2'b00, 12'h033, 0);
    do_op(1, 2'b11, 12'h044, 0);
    do_op(1, 2'b10, '0, 0);
    do_op(0, 2'b00, '0, 0);

    for (int i = 0; i < 800; i++) begin
      int r;
      logic [1:0] op;
      r = int'($urandom_range(0, 99));
      op = (r < 45) ? 2'b00 : (r < 70) ? 2'b01 : (r < 85) ? 2'b10 : 2'b11;
      do_op($urandom_range(0, 9) != 0, op, DATA_W'($urandom), $urandom_range(0, 4) == 0);
    end
    do_op(0, 2'b00, '0, 0);
    @(posedge clk); #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
